// File: rtl/vram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_pkg
//  Purpose  : Shared types and constants for the video-memory arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 8;

    // Arbiter sequencing: pick a requester, run the SRAM cycle, report done.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    // Which requester owns the SRAM for the transfer in flight.
    typedef enum logic {
        GNT_VIDEO = 1'b0,
        GNT_CPU   = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter_if
//  Purpose  : Bundles the video port, CPU port and SRAM pins of the arbiter.
//             slave  = arbiter view, master = requesters + SRAM view.
//  Revision : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) ();

    // Video (CRT controller) read port
    logic [ADDR_W-1:0] VAD;
    logic              vram_cs;
    logic [DATA_W-1:0] VDI;
    logic              vram_complete;

    // CPU bus port
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_di;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_rw;
    logic              cpu_cs;
    logic              cpu_ready;

    // External single-port SRAM
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] sram_din;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport slave (
        input  VAD, vram_cs, cpu_addr, cpu_di, cpu_rw, cpu_cs, sram_din,
        output VDI, vram_complete, cpu_do, cpu_ready,
               sram_addr, sram_dout, sram_oe_n, sram_we_n
    );

    modport master (
        output VAD, vram_cs, cpu_addr, cpu_di, cpu_rw, cpu_cs, sram_din,
        input  VDI, vram_complete, cpu_do, cpu_ready,
               sram_addr, sram_dout, sram_oe_n, sram_we_n
    );

endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares one 8-bit SRAM between video fetches (priority) and the
//             CPU bus, alternating on contention so neither side starves.
//  Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  wire           clk,
    input  wire           rst,
    vram_arbiter_if.slave bus
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    // Out-of-range access length cannot be represented by the 4-bit counter.
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("vram_arbiter: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
        end
    endgenerate

    state_t            r_state;
    state_t            w_next_state;
    grant_t            r_grant;
    grant_t            r_last_grant;
    logic              r_is_write;
    logic [3:0]        r_cnt;
    logic              r_vid_armed;
    logic              r_cpu_armed;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_dout;
    logic [DATA_W-1:0] r_vdi;
    logic [DATA_W-1:0] r_cpu_do;

    logic w_vid_pend;
    logic w_cpu_pend;
    logic w_pick_cpu;
    logic w_grant;
    logic w_last_access;
    logic w_oe_n;
    logic w_we_n;
    logic w_vid_done;
    logic w_cpu_done;

    // A held-high cs is only a new request once it has been seen low again.
    assign w_vid_pend    = bus.vram_cs & r_vid_armed;
    assign w_cpu_pend    = bus.cpu_cs  & r_cpu_armed;
    // Video wins unless it was served last and the CPU is also waiting.
    assign w_pick_cpu    = w_cpu_pend & (~w_vid_pend | (r_last_grant == GNT_VIDEO));
    assign w_grant       = (r_state == IDLE) & (w_vid_pend | w_cpu_pend);
    assign w_last_access = (r_state == ACCESS) & (r_cnt == 4'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_grant) w_next_state = ACCESS;
            ACCESS:   if (r_cnt == 4'd1) w_next_state = COMPLETE;
            COMPLETE: w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Output decode: strobes during ACCESS, single completion pulse in COMPLETE.
    always_comb begin
        w_oe_n     = 1'b1;
        w_we_n     = 1'b1;
        w_vid_done = 1'b0;
        w_cpu_done = 1'b0;
        case (r_state)
            ACCESS: begin
                if (r_is_write) w_we_n = 1'b0;
                else            w_oe_n = 1'b0;
            end
            COMPLETE: begin
                if (r_grant == GNT_VIDEO) w_vid_done = 1'b1;
                else                      w_cpu_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Transfer datapath: latch request at grant, count access, capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= GNT_VIDEO;
            r_last_grant <= GNT_CPU;
            r_is_write   <= 1'b0;
            r_cnt        <= 4'd0;
            r_sram_addr  <= '0;
            r_sram_dout  <= '0;
            r_vdi        <= '0;
            r_cpu_do     <= '0;
        end else begin
            if (w_grant) begin
                r_grant     <= w_pick_cpu ? GNT_CPU : GNT_VIDEO;
                r_sram_addr <= w_pick_cpu ? bus.cpu_addr : bus.VAD;
                r_is_write  <= w_pick_cpu & ~bus.cpu_rw;
                if (w_pick_cpu && !bus.cpu_rw) r_sram_dout <= bus.cpu_di;
                r_cnt       <= c_WAIT;
            end
            if (r_state == ACCESS) r_cnt <= r_cnt - 4'd1;
            // Data lands at the edge into COMPLETE, so it is valid with the pulse.
            if (w_last_access && !r_is_write) begin
                if (r_grant == GNT_VIDEO) r_vdi    <= bus.sram_din;
                else                      r_cpu_do <= bus.sram_din;
            end
            if (r_state == COMPLETE) r_last_grant <= r_grant;
        end
    end

    // Video arming: re-arm whenever cs is low, disarm on its completion.
    always_ff @(posedge clk) begin
        if (rst)               r_vid_armed <= 1'b1;
        else if (!bus.vram_cs) r_vid_armed <= 1'b1;
        else if (w_vid_done)   r_vid_armed <= 1'b0;
    end

    // CPU arming: same rule as the video port.
    always_ff @(posedge clk) begin
        if (rst)              r_cpu_armed <= 1'b1;
        else if (!bus.cpu_cs) r_cpu_armed <= 1'b1;
        else if (w_cpu_done)  r_cpu_armed <= 1'b0;
    end

    assign bus.VDI           = r_vdi;
    assign bus.cpu_do        = r_cpu_do;
    assign bus.vram_complete = w_vid_done;
    assign bus.cpu_ready     = w_cpu_done;
    assign bus.sram_addr     = r_sram_addr;
    assign bus.sram_dout     = r_sram_dout;
    assign bus.sram_oe_n     = w_oe_n;
    assign bus.sram_we_n     = w_we_n;

endmodule
`default_nettype wire
